// File: rtl/aesl_deadlock_idx0_monitor_pkg.sv
// Shared definitions for the deadlock index-0 monitor: counter width,
// default parameter values and the stall-counter type.
package aesl_deadlock_idx0_monitor_pkg;

  localparam int CNT_W               = 16;
  localparam int DEF_NUM_AXIS        = 10;
  localparam int DEF_NUM_INST        = 1;
  localparam int DEF_STALL_THRESHOLD = 1024;

  typedef logic [CNT_W-1:0] stall_cnt_t;

endpackage

// File: rtl/aesl_deadlock_idx0_monitor_stall_counter.sv
// deadlock_stall_counter: saturating count of consecutive stall cycles.
// The count clears on any non-stall cycle and stops at STALL_THRESHOLD.
// 'reached' is combinational: it is high during the cycle that is the
// STALL_THRESHOLD-th (or later) consecutive stall. The parent registers it,
// so the flag appears on the edge that samples that cycle.
module deadlock_stall_counter
  import aesl_deadlock_idx0_monitor_pkg::*;
#(
  parameter int STALL_THRESHOLD = DEF_STALL_THRESHOLD
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  output logic reached
);

  localparam stall_cnt_t THR    = stall_cnt_t'(STALL_THRESHOLD);
  localparam stall_cnt_t THR_M1 = stall_cnt_t'(STALL_THRESHOLD - 1);

  stall_cnt_t r_count;
  logic       w_at_limit;

  // The current stall completes the run when the stalls already counted
  // are at least THRESHOLD-1 (the counter never exceeds THRESHOLD).
  assign w_at_limit = (r_count >= THR_M1);
  assign reached    = stall & w_at_limit;

  // Consecutive-stall counter: clear on non-stall, saturate at threshold.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!stall) begin
      r_count <= '0;
    end else if (r_count != THR) begin
      r_count <= stall_cnt_t'(r_count + 1'b1);
    end
  end

endmodule

// File: rtl/aesl_deadlock_idx0_monitor.sv
// aesl_deadlock_idx0_monitor: flags a kernel deadlock after a run of
// consecutive stall cycles and captures which streams were blocked.
// A stall cycle has any stream or instance blocked while not every instance
// is idle (all idle means the kernel finished, which is never a deadlock).
// Configuration macro DEADLOCK_STICKY_EN: when defined, block and block_src
// latch until reset; otherwise block drops on the first non-stall cycle and
// block_src keeps its last snapshot.
module aesl_deadlock_idx0_monitor
  import aesl_deadlock_idx0_monitor_pkg::*;
#(
  parameter int NUM_AXIS        = DEF_NUM_AXIS,
  parameter int NUM_INST        = DEF_NUM_INST,
  parameter int STALL_THRESHOLD = DEF_STALL_THRESHOLD
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  output logic                block,
  output logic [NUM_AXIS-1:0] block_src
);

  logic                w_any_axis;
  logic                w_any_inst;
  logic                w_all_idle;
  logic                w_stall;
  logic                w_reached;
  logic                w_rise;
  logic                r_block;
  logic [NUM_AXIS-1:0] r_block_src;

  assign w_any_axis = |axis_block_sigs;
  assign w_any_inst = |inst_block_sigs;
  assign w_all_idle = &inst_idle_sigs;
  // All-idle overrides any blocked indication in the same cycle.
  assign w_stall    = (w_any_axis | w_any_inst) & ~w_all_idle;

  deadlock_stall_counter #(
    .STALL_THRESHOLD (STALL_THRESHOLD)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .stall   (w_stall),
    .reached (w_reached)
  );

  // Snapshot only on the cycle block goes from 0 to 1.
  assign w_rise = w_reached & ~r_block;

  // Deadlock flag and blocked-stream snapshot registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_block     <= 1'b0;
      r_block_src <= '0;
    end else begin
`ifdef DEADLOCK_STICKY_EN
      r_block <= r_block | w_reached;
`else
      r_block <= w_reached;
`endif
      if (w_rise) begin
        r_block_src <= axis_block_sigs;
      end
    end
  end

  assign block     = r_block;
  assign block_src = r_block_src;

endmodule

// File: tb/tb_aesl_deadlock_idx0_monitor.sv
// Bench for aesl_deadlock_idx0_monitor with STALL_THRESHOLD = 8.
// Honours DEADLOCK_STICKY_EN the same way as the design.
module tb_aesl_deadlock_idx0_monitor;

  localparam int NA  = 10;
  localparam int NI  = 1;
  localparam int THR = 8;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NA-1:0] axis_block_sigs = '0;
  logic [NI-1:0] inst_idle_sigs  = '0;
  logic [NI-1:0] inst_block_sigs = '0;
  logic          block;
  logic [NA-1:0] block_src;

  always #5 clock = ~clock;

  aesl_deadlock_idx0_monitor #(
    .NUM_AXIS        (NA),
    .NUM_INST        (NI),
    .STALL_THRESHOLD (THR)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block),
    .block_src       (block_src)
  );

`ifdef DEADLOCK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // ---------------- reference model ----------------
  // run: length of the current unbroken run of stall cycles (unbounded).
  int            total = 0;
  int            bad   = 0;
  int            run   = 0;
  logic          m_block = 1'b0;
  logic [NA-1:0] m_src   = '0;

  function automatic bit is_stall(logic [NA-1:0] a, logic [NI-1:0] idle,
                                  logic [NI-1:0] blk);
    bit any_blocked;
    bit all_idle;
    any_blocked = (a != 0) || (blk != 0);
    all_idle    = (idle == {NI{1'b1}});
    return any_blocked && !all_idle;
  endfunction

  task automatic model_edge();
    bit hit;
    if (!reset) begin
      run     = 0;
      m_block = 1'b0;
      m_src   = '0;
    end else begin
      if (is_stall(axis_block_sigs, inst_idle_sigs, inst_block_sigs)) run++;
      else run = 0;
      hit = (run >= THR);
      if (hit && !m_block) m_src = axis_block_sigs;
      if (STICKY) m_block = m_block | hit;
      else        m_block = hit;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs(string tag);
    total++;
    assert (block === m_block) else begin
      bad++;
      $error("FAIL %s block: got %0b expected %0b", tag, block, m_block);
    end
    total++;
    assert (block_src === m_src) else begin
      bad++;
      $error("FAIL %s block_src: got %h expected %h", tag, block_src, m_src);
    end
  endtask

  task automatic expect_const(string tag, logic exp_b, logic [NA-1:0] exp_s);
    total++;
    assert (block === exp_b) else begin
      bad++;
      $error("FAIL %s block: got %0b expected %0b", tag, block, exp_b);
    end
    total++;
    assert (block_src === exp_s) else begin
      bad++;
      $error("FAIL %s block_src: got %h expected %h", tag, block_src, exp_s);
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, let the model see the rising edge, then
  // sample outputs 1 time unit after the rising edge.
  task automatic step(string tag, logic rst, logic [NA-1:0] a,
                      logic [NI-1:0] idle, logic [NI-1:0] blk);
    @(negedge clock);
    reset           = rst;
    axis_block_sigs = a;
    inst_idle_sigs  = idle;
    inst_block_sigs = blk;
    @(posedge clock);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic repeat_step(string tag, int n, logic [NA-1:0] a,
                             logic [NI-1:0] idle, logic [NI-1:0] blk);
    for (int k = 0; k < n; k++) step(tag, 1'b1, a, idle, blk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    step("rst0", 1'b0, '0, '0, '0);
    step("rst1", 1'b0, 10'h2AA, '0, '0);
    expect_const("reset_state", 1'b0, 10'h000);

    // 8 stall cycles of stream 0 -> block on 8th edge
    repeat_step("s1_pre", 7, 10'h001, '0, '0);
    expect_const("s1_before_8th", 1'b0, 10'h000);
    step("s1_8th", 1'b1, 10'h001, '0, '0);
    expect_const("s1_block", 1'b1, 10'h001);

    // one non-stall cycle after block
    step("s5_nonstall", 1'b1, '0, '0, '0);
    expect_const("s5_after_gap", STICKY, 10'h001);

    // back to deadlock, then reset while block = 1
    repeat_step("s6_restall", THR, 10'h0F0, '0, '0);
    step("s6_reset", 1'b0, 10'h0F0, '0, '0);
    expect_const("s6_reset_clears", 1'b0, 10'h000);
    repeat_step("s6_pre", THR - 1, 10'h010, '0, '0);
    expect_const("s6_before_8th", 1'b0, 10'h000);
    step("s6_8th", 1'b1, 10'h010, '0, '0);
    expect_const("s6_block_again", 1'b1, 10'h010);

    // 7 stalls, one gap, 8 more: block only on the 8th after the gap
    step("s2_rst", 1'b0, '0, '0, '0);
    repeat_step("s2_first7", THR - 1, 10'h004, '0, '0);
    step("s2_gap", 1'b1, '0, '0, '0);
    repeat_step("s2_next7", THR - 1, 10'h004, '0, '0);
    expect_const("s2_before_8th", 1'b0, 10'h000);
    step("s2_8th", 1'b1, 10'h004, '0, '0);
    expect_const("s2_block", 1'b1, 10'h004);

    // everything blocked but all instances idle: never a deadlock
    step("s3_rst", 1'b0, '0, '0, '0);
    repeat_step("s3_idle", 20, 10'h3FF, 1'b1, 1'b1);
    expect_const("s3_no_block", 1'b0, 10'h000);

    // instance blocked, no streams blocked
    step("s4_rst", 1'b0, '0, '0, '0);
    repeat_step("s4_inst", THR, '0, '0, 1'b1);
    expect_const("s4_block", 1'b1, 10'h000);

    // randomized: long stall runs with occasional gaps, idle and resets
    step("rnd_rst", 1'b0, '0, '0, '0);
    for (int i = 0; i < 600; i++) begin
      logic          rst;
      logic [NA-1:0] a;
      logic [NI-1:0] idle;
      logic [NI-1:0] blk;
      rst  = ($urandom_range(0, 99) != 0);
      a    = ($urandom_range(0, 9) == 0) ? '0 : NA'($urandom_range(0, 1023));
      idle = ($urandom_range(0, 19) == 0) ? '1 : '0;
      blk  = ($urandom_range(0, 3) == 0) ? NI'($urandom_range(0, 1)) : '0;
      step("random", rst, a, idle, blk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
